// File: rtl/t3_affine_pkg.sv
// Shared definitions for the tap-3 affine MCM sharing block.
// XW/PW are the default sample and product widths; phase 0 is the integer position, whose
// coefficient (64) is applied locally as a shift instead of being taken from the MCM.
package t3_affine_pkg;

  localparam int unsigned XW           = 11;
  localparam int unsigned PW           = 17;
  localparam int unsigned NUM_PHASES   = 15;
  localparam int unsigned CENTER_COEF  = 64;
  localparam int unsigned CENTER_SHIFT = $clog2(CENTER_COEF);

  typedef logic [3:0]           frac_t;
  typedef logic signed [PW-1:0] product_t;

endpackage

// File: rtl/t3_affine_mcm_arb_rr.sv
// t3_rr_arbiter: NREQ-wide grant with a rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : per-requester valid
//   en_i       : downstream can take a grant this cycle
//   gnt_o      : one-hot grant, zero when en_i is low or nobody requests
//   gnt_any_o  : some requester would win (independent of en_i)
//   gnt_id_o   : index of the would-be winner
// Build option: AFF_MCM_FIXED_PRIO_EN selects fixed priority (index 0 highest), no pointer.
module t3_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            gnt_any_o,
  output logic [IDW-1:0]  gnt_id_o
);

`ifdef AFF_MCM_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Scan high to low so the lowest requesting index is written last and wins.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_id_o  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_any_o = 1'b1;
        gnt_id_o  = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q, ptr_d;

  // Scan offsets from farthest to nearest so the first requester at or after the
  // pointer (offset 0 side) is written last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_any_o = 1'b0;
    gnt_id_o  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (req_i[idx]) begin
        gnt_any_o = 1'b1;
        gnt_id_o  = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_o && en_i) begin
      ptr_d = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      gnt_o[i] = en_i && gnt_any_o && (gnt_id_o == IDW'(i));
    end
  end

endmodule

// File: rtl/t3_affine_mcm_arb.sv
// t3_affine_mcm_arb: shares one external tap-3 affine MCM between NREQ requesters.
// Stage 1 registers the granted sample (drives mcm_x) with its phase and id; stage 2
// registers the selected product and id and presents it on resp_*.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid/req_ready/req_x/req_frac : per-requester request handshake (flattened)
//   mcm_x       : registered sample to the MCM
//   mcm_y       : fifteen MCM products, phase f at [(f-1)*PW +: PW]
//   resp_valid/resp_ready/resp_id/resp_prod : tagged product output
// Build option: AFF_MCM_FIXED_PRIO_EN (fixed priority arbitration, see t3_rr_arbiter).
module t3_affine_mcm_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XW   = t3_affine_pkg::XW,
  parameter int unsigned PW   = t3_affine_pkg::PW,
  parameter int unsigned IDW  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*XW-1:0]          req_x,
  input  logic [NREQ*4-1:0]           req_frac,
  output logic [XW-1:0]               mcm_x,
  input  logic [t3_affine_pkg::NUM_PHASES*PW-1:0] mcm_y,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [IDW-1:0]              resp_id,
  output logic [PW-1:0]               resp_prod
);

  import t3_affine_pkg::*;

  logic           s1_valid_q, s1_valid_d;
  logic [XW-1:0]  s1_x_q, s1_x_d;
  frac_t          s1_frac_q, s1_frac_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;

  logic           s2_valid_q, s2_valid_d;
  logic [PW-1:0]  s2_prod_q, s2_prod_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;

  logic           s1_adv, s2_adv;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [XW-1:0]  win_x;
  frac_t          win_frac;
  logic [PW-1:0]  center_ext;
  logic [PW-1:0]  sel_prod;

  assign s2_adv = !s2_valid_q || resp_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  t3_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (s1_adv),
    .gnt_o     (req_ready),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

  // Winner data mux; loop keeps the index in range for any IDW.
  always_comb begin
    win_x    = '0;
    win_frac = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_id == IDW'(i)) begin
        win_x    = req_x[i*XW +: XW];
        win_frac = req_frac[i*4 +: 4];
      end
    end
  end

  // Phase 0 uses the local x*64; other phases pick the MCM slice for that phase.
  always_comb begin
    center_ext = {{(PW - XW){s1_x_q[XW-1]}}, s1_x_q};
    sel_prod   = center_ext << CENTER_SHIFT;
    for (int unsigned f = 1; f <= NUM_PHASES; f++) begin
      if (s1_frac_q == frac_t'(f)) begin
        sel_prod = mcm_y[(f-1)*PW +: PW];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_frac_d  = s1_frac_q;
    s1_id_d    = s1_id_q;
    if (s1_adv) begin
      s1_valid_d = gnt_any;
      if (gnt_any) begin
        s1_x_d    = win_x;
        s1_frac_d = win_frac;
        s1_id_d   = gnt_id;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_id_d    = s2_id_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = sel_prod;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_frac_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_frac_q  <= s1_frac_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_prod_q  <= s2_prod_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign mcm_x      = s1_x_q;
  assign resp_valid = s2_valid_q;
  assign resp_id    = s2_id_q;
  assign resp_prod  = s2_prod_q;

endmodule

// File: tb/tb_t3_affine_mcm_arb.sv
module tb_t3_affine_mcm_arb;

  localparam int NREQ = 2;
  localparam int XW   = 11;
  localparam int PW   = 17;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XW-1:0]   req_x;
  logic [NREQ*4-1:0]    req_frac;
  logic [XW-1:0]        mcm_x;
  logic [15*PW-1:0]     mcm_y;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [PW-1:0]        resp_prod;

  always #5 clk = ~clk;

  t3_affine_mcm_arb #(
    .NREQ (NREQ),
    .XW   (XW),
    .PW   (PW),
    .IDW  (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_frac   (req_frac),
    .mcm_x      (mcm_x),
    .mcm_y      (mcm_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_prod  (resp_prod)
  );

  // MCM model: tap-3 coefficients of the 1/16-phase 8-tap filter (phase 3 -> 13, 15 -> 63).
  function automatic int coef(input int f);
    case (f)
      1: return 4;   2: return 8;   3: return 13;  4: return 17;  5: return 22;
      6: return 27;  7: return 33;  8: return 40;  9: return 45;  10: return 50;
      11: return 52; 12: return 56; 13: return 60; 14: return 62; 15: return 63;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_prod(input int x, input int f);
    return (f == 0) ? x * 64 : x * coef(f);
  endfunction

  always_comb begin
    int p;
    p     = 0;
    mcm_y = '0;
    for (int f = 1; f <= 15; f++) begin
      p = $signed(mcm_x) * coef(f);
      mcm_y[(f-1)*PW +: PW] = p[PW-1:0];
    end
  end

  typedef struct {
    int id;
    int prod;
    int cyc;
    bit chk_lat;
  } sb_t;

  sb_t sb_q[$];
  int  gnt_log[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  bit  lat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accept watcher: every handshake pushes the model's expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_t e;
          int  x, f;
          x = $signed(req_x[i*XW +: XW]);
          f = int'(req_frac[i*4 +: 4]);
          e.id = i;
          e.prod = exp_prod(x, f);
          e.cyc = cyc;
          e.chk_lat = lat_mode;
          sb_q.push_back(e);
          gnt_log.push_back(i);
        end
      end
    end
  end

  // Monitor: compares each delivered product against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_prod", $signed(resp_prod), e.prod);
        if (e.chk_lat) chk("latency", cyc - e.cyc, 2);
      end
    end
  end

  task automatic set_req(input int i, input bit v, input int x, input int f);
    logic [31:0] xv, fv;
    xv = x;
    fv = f;
    req_valid[i] = v;
    req_x[i*XW +: XW] = xv[XW-1:0];
    req_frac[i*4 +: 4] = fv[3:0];
  endtask

  task automatic send(input int i, input int x, input int f);
    int n;
    set_req(i, 1'b1, x, f);
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60) chk("drain_timeout", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PW-1:0]  hold_prod;
    logic [IDW-1:0] hold_id;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_frac   = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_prod", resp_prod, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_mcm_x", mcm_x, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single-requester vectors with latency checking.
    lat_mode = 1'b1;
    send(0, 100, 3);     // 1300
    send(0, -1024, 15);  // -64512
    send(0, 1023, 0);    // 65472 via local shift
    drain();
    lat_mode = 1'b0;

    // Both requesting continuously; pointer sits at 1 after the grants to 0 above.
    gnt_log.delete();
    set_req(0, 1'b1, -7, 8);
    set_req(1, 1'b1, 5, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("alt_count", gnt_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
`ifdef AFF_MCM_FIXED_PRIO_EN
      chk("fixed_order", (k < gnt_log.size()) ? gnt_log[k] : -1, 0);
`else
      chk("alt_order", (k < gnt_log.size()) ? gnt_log[k] : -1, (k % 2 == 0) ? 1 : 0);
`endif
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lone_req1_ready", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drain();

    // Backpressure: at most two accepted, output frozen, then in-order drain.
    gnt_log.delete();
    resp_ready = 1'b0;
    set_req(0, 1'b1, 300, 2);
    set_req(1, 1'b1, -300, 14);
    repeat (2) @(posedge clk);
    @(negedge clk);
    hold_prod = resp_prod;
    hold_id = resp_id;
    chk("bp_resp_valid", resp_valid, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_prod_stable", resp_prod, hold_prod);
      chk("bp_id_stable", resp_id, hold_id);
    end
    chk("bp_ready_low", req_ready, 0);
    chk("bp_accepted", gnt_log.size(), 2);
    @(posedge clk);
    #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();

    // Reset with both stages full and pointer at 1.
    send(0, 50, 4);
    drain();
    resp_ready = 1'b0;
    set_req(0, 1'b1, 11, 6);
    set_req(1, 1'b1, 9, 5);
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("pre_rst_full", resp_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_prod", resp_prod, 0);
    chk("mid_rst_mcm_x", mcm_x, 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    set_req(0, 1'b1, -1, 9);
    set_req(1, 1'b1, 2, 10);
    @(negedge clk);
    chk("post_rst_first_grant", req_ready, 2'b01);
    chk("post_rst_resp_valid", resp_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    req_valid = '0;
    drain();

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
